branch_resolve: RTL and testbench
=================================

BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 The block SHALL have exactly one clock and SHALL use an asynchronous, active-low reset.
REQ-002 clk  input  1  sole clock, rising-edge.
REQ-003 rst  input  1  asynchronous active-low reset (0 = reset).
REQ-004 validD  input  1  decode stage presents a valid instruction.
REQ-005 branchD / jalD / jalrD  input  1 each  one-hot control class from decoder.
REQ-006 funct3D  input  3  branch condition code.
REQ-007 rs1D, rs2D  input  32  register operand values.
REQ-008 immD  input  32  sign-extended immediate.
REQ-009 PCD  input  32  PC of the decode-stage instruction.
REQ-010 PCsrcE  output  1  redirect fetch to PCplusImmE.
REQ-011 PCplusImmE  output  32  redirect target.
REQ-012 linkE  output  32  PC+4 of the execute instruction, for JAL/JALR writeback.
REQ-013 validE  output  1  execute register holds a real (non-bubble) instruction.
REQ-014 flushD  output  1  decode-stage instruction is wrong-path and is being discarded.

Function
REQ-015 The ID/EX register SHALL capture all D inputs on each rising clk; it SHALL capture a bubble (validE=0, all controls 0) when validD=0 or flushD=1.
REQ-016 Latency: an instruction presented at cycle N SHALL produce PCsrcE/PCplusImmE at cycle N+1, computed combinationally from the ID/EX register.
REQ-017 Taken condition: BEQ 000 eq, BNE 001 ne, BLT 100 signed lt, BGE 101 signed ge, BLTU 110 unsigned lt, BGEU 111 unsigned ge; 010/011 never taken.
REQ-018 PCsrcE SHALL equal validE & (jalE | jalrE | (branchE & cond)).
REQ-019 Target SHALL be (rs1E+immE) & ~1 for JALR, else PCE+immE; addition is modulo 2^32 (wrap, no flag).
REQ-020 linkE SHALL be PCE+4 modulo 2^32; PCplusImmE SHALL be 0 when PCsrcE=0.
REQ-021 FSM states: RUN, SQUASH. RUN->SQUASH when PCsrcE=1; SQUASH->RUN unconditionally after one cycle.
REQ-022 flushD SHALL be 1 when PCsrcE=1 (in RUN) and for the whole SQUASH cycle, discarding both wrong-path instructions already in fetch/decode.
REQ-023 PCsrcE SHALL never assert in SQUASH (ID/EX holds a bubble); if any control class inputs are non-one-hot, jalrD SHALL take priority over jalD, and jalD over branchD.
REQ-024 Back-to-back taken branches SHALL be impossible by construction; a not-taken branch followed by a taken one SHALL redirect on the second.

Reset
REQ-025 While rst=0: state=RUN, ID/EX register cleared, validE=0, PCsrcE=0, PCplusImmE=0, linkE=0, flushD=0.
REQ-026 Reset deasserted mid-SQUASH SHALL resume in RUN with no residual flush.

Configuration
REQ-027 With BRANCH_STATS_EN defined, the block SHALL add outputs branch_cnt[31:0] (increments per validE branch/jal/jalr) and taken_cnt[31:0] (increments per PCsrcE=1), both wrapping at 2^32 and cleared by reset.
REQ-028 Without BRANCH_STATS_EN, the counters and their ports SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-029 A shared package SHALL hold the funct3 branch-code constants and the RUN/SQUASH state encoding.
REQ-030 Comparison SHALL live in one sub-module branch_cmp (rs1, rs2, funct3 -> taken); all else is in branch_resolve.

Verification
REQ-031 BEQ, rs1=rs2=5, PCD=0x100, immD=0x20 -> next cycle PCsrcE=1, PCplusImmE=0x120, flushD=1 for 2 cycles.
REQ-032 BLT rs1=0xFFFFFFFF, rs2=1 -> taken; BLTU same operands -> not taken, flushD stays 0.
REQ-033 JALR rs1=0x203, immD=0x4 -> PCplusImmE=0x206, linkE=PCD+4.
REQ-034 Taken branch followed by validD=1 instructions for 2 cycles -> both captured as bubbles, validE=0 for 2 cycles, then normal flow.
REQ-035 PCD=0xFFFFFFFC, JAL immD=0x8 -> PCplusImmE=0x4, linkE=0x0.
REQ-036 rst=0 asserted during SQUASH -> all outputs 0 immediately; after release, first valid non-branch yields validE=1, PCsrcE=0 (with BRANCH_STATS_EN: counters read 0).

Source files
------------

// File: rtl/branch_resolve_pkg.sv
// Shared definitions for the branch resolution block: branch condition codes
// (funct3) and the redirect FSM state encoding.
package branch_resolve_pkg;

    localparam logic [2:0] F3Beq  = 3'b000;
    localparam logic [2:0] F3Bne  = 3'b001;
    localparam logic [2:0] F3Blt  = 3'b100;
    localparam logic [2:0] F3Bge  = 3'b101;
    localparam logic [2:0] F3Bltu = 3'b110;
    localparam logic [2:0] F3Bgeu = 3'b111;

    typedef enum logic {
        StRun    = 1'b0,
        StSquash = 1'b1
    } state_e;

endpackage

// File: rtl/branch_cmp.sv
// Branch condition evaluator.
// Ports:
//   rs1_i, rs2_i  operand values
//   funct3_i      branch condition code
//   taken_o       1 when the condition holds (codes 010/011 are never taken)
module branch_cmp
    import branch_resolve_pkg::*;
(
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    input  logic [2:0]  funct3_i,
    output logic        taken_o
);

    logic eq;
    logic lt;
    logic ltu;

    assign eq  = (rs1_i == rs2_i);
    assign lt  = ($signed(rs1_i) < $signed(rs2_i));
    assign ltu = (rs1_i < rs2_i);

    always_comb begin
        taken_o = 1'b0;
        case (funct3_i)
            F3Beq:   taken_o = eq;
            F3Bne:   taken_o = ~eq;
            F3Blt:   taken_o = lt;
            F3Bge:   taken_o = ~lt;
            F3Bltu:  taken_o = ltu;
            F3Bgeu:  taken_o = ~ltu;
            default: taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve.sv
// Branch/jump resolution in execute: ID/EX register, taken evaluation, redirect
// target and link computation, and a two-state squash FSM that flushes the two
// wrong-path instructions behind a redirect.
// Ports:
//   clk, rst                  clock and asynchronous active-low reset
//   validD, branchD/jalD/jalrD, funct3D, rs1D, rs2D, immD, PCD   decode inputs
//   PCsrcE, PCplusImmE        redirect request and target (target 0 when idle)
//   linkE                     PC+4 of the execute instruction (0 for a bubble)
//   validE                    execute register holds a real instruction
//   flushD                    decode-stage instruction is being discarded
// Optional feature: define BRANCH_STATS_EN to add branch_cnt / taken_cnt.
module branch_resolve
    import branch_resolve_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        validD,
    input  logic        branchD,
    input  logic        jalD,
    input  logic        jalrD,
    input  logic [2:0]  funct3D,
    input  logic [31:0] rs1D,
    input  logic [31:0] rs2D,
    input  logic [31:0] immD,
    input  logic [31:0] PCD,
    output logic        PCsrcE,
    output logic [31:0] PCplusImmE,
    output logic [31:0] linkE,
    output logic        validE,
    output logic        flushD
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0] branch_cnt,
    output logic [31:0] taken_cnt
`endif
);

    state_e      state_q, state_d;

    logic        valid_q,  valid_d;
    logic        branch_q, branch_d;
    logic        jal_q,    jal_d;
    logic        jalr_q,   jalr_d;
    logic [2:0]  funct3_q;
    logic [31:0] rs1_q, rs2_q, imm_q, pc_q;

    logic        cond_taken;
    logic [31:0] target;

    // Bubble when nothing valid arrives or the decode instruction is wrong-path.
    // Non-one-hot controls resolve as jalr > jal > branch.
    always_comb begin
        valid_d  = validD & ~flushD;
        jalr_d   = valid_d & jalrD;
        jal_d    = valid_d & jalD & ~jalrD;
        branch_d = valid_d & branchD & ~jalD & ~jalrD;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q  <= 1'b0;
            branch_q <= 1'b0;
            jal_q    <= 1'b0;
            jalr_q   <= 1'b0;
            funct3_q <= 3'b000;
            rs1_q    <= 32'd0;
            rs2_q    <= 32'd0;
            imm_q    <= 32'd0;
            pc_q     <= 32'd0;
        end else begin
            valid_q  <= valid_d;
            branch_q <= branch_d;
            jal_q    <= jal_d;
            jalr_q   <= jalr_d;
            funct3_q <= funct3D;
            rs1_q    <= rs1D;
            rs2_q    <= rs2D;
            imm_q    <= immD;
            pc_q     <= PCD;
        end
    end

    branch_cmp u_branch_cmp (
        .rs1_i    (rs1_q),
        .rs2_i    (rs2_q),
        .funct3_i (funct3_q),
        .taken_o  (cond_taken)
    );

    always_comb begin
        target = jalr_q ? ((rs1_q + imm_q) & ~32'd1) : (pc_q + imm_q);
    end

    // FSM: a redirect in RUN costs exactly one SQUASH cycle.
    always_comb begin
        state_d = state_q;
        PCsrcE  = 1'b0;
        flushD  = 1'b0;
        unique case (state_q)
            StRun: begin
                PCsrcE = valid_q & (jal_q | jalr_q | (branch_q & cond_taken));
                flushD = PCsrcE;
                if (PCsrcE) begin
                    state_d = StSquash;
                end
            end
            StSquash: begin
                flushD  = 1'b1;
                state_d = StRun;
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    assign validE     = valid_q;
    assign PCplusImmE = PCsrcE ? target : 32'd0;
    assign linkE      = valid_q ? (pc_q + 32'd4) : 32'd0;

`ifdef BRANCH_STATS_EN
    logic [31:0] branch_cnt_q, taken_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            branch_cnt_q <= 32'd0;
            taken_cnt_q  <= 32'd0;
        end else begin
            if (valid_q & (branch_q | jal_q | jalr_q)) begin
                branch_cnt_q <= branch_cnt_q + 32'd1;
            end
            if (PCsrcE) begin
                taken_cnt_q <= taken_cnt_q + 32'd1;
            end
        end
    end

    assign branch_cnt = branch_cnt_q;
    assign taken_cnt  = taken_cnt_q;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
module tb_branch_resolve;

    logic        clk = 1'b0;
    logic        rst;
    logic        validD, branchD, jalD, jalrD;
    logic [2:0]  funct3D;
    logic [31:0] rs1D, rs2D, immD, PCD;
    logic        PCsrcE, validE, flushD;
    logic [31:0] PCplusImmE, linkE;
`ifdef BRANCH_STATS_EN
    logic [31:0] branch_cnt, taken_cnt;
`endif

    branch_resolve dut (
        .clk        (clk),
        .rst        (rst),
        .validD     (validD),
        .branchD    (branchD),
        .jalD       (jalD),
        .jalrD      (jalrD),
        .funct3D    (funct3D),
        .rs1D       (rs1D),
        .rs2D       (rs2D),
        .immD       (immD),
        .PCD        (PCD),
        .PCsrcE     (PCsrcE),
        .PCplusImmE (PCplusImmE),
        .linkE      (linkE),
        .validE     (validE),
        .flushD     (flushD)
`ifdef BRANCH_STATS_EN
        ,
        .branch_cnt (branch_cnt),
        .taken_cnt  (taken_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid;
        logic        br;
        logic        jal;
        logic        jalr;
        logic [2:0]  f3;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [31:0] pc;
    } in_t;

    typedef struct packed {
        logic        valid;
        logic        pcsrc;
        logic        flush;
        logic        ctl;
        logic [31:0] tgt;
        logic [31:0] link;
    } out_t;

    typedef struct packed {
        in_t  i;
        out_t o;
    } vec_t;

    int checks = 0;
    int errors = 0;
    out_t sb[$];
    int unsigned exp_br_cnt = 0;
    int unsigned exp_tk_cnt = 0;
    in_t idle_in = '0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic in_t mki(input logic v, input logic b, input logic j, input logic jr,
                                input logic [2:0] f3, input logic [31:0] r1,
                                input logic [31:0] r2, input logic [31:0] im,
                                input logic [31:0] pc);
        in_t x;
        x.valid = v; x.br = b; x.jal = j; x.jalr = jr; x.f3 = f3;
        x.rs1 = r1; x.rs2 = r2; x.imm = im; x.pc = pc;
        return x;
    endfunction

    function automatic out_t mko(input logic v, input logic p, input logic f,
                                 input logic [31:0] t, input logic [31:0] l);
        out_t x;
        x.valid = v; x.pcsrc = p; x.flush = f; x.ctl = 1'b0; x.tgt = t; x.link = l;
        return x;
    endfunction

    task automatic drive(input in_t in);
        validD = in.valid; branchD = in.br; jalD = in.jal; jalrD = in.jalr;
        funct3D = in.f3; rs1D = in.rs1; rs2D = in.rs2; immD = in.imm; PCD = in.pc;
    endtask

    // Drive one decode instruction, queue its expected execute-cycle result,
    // advance one edge and compare.
    task automatic step(input in_t in, input out_t exp, input string nm);
        out_t e;
        out_t x;
        e = exp;
        e.ctl = exp.valid & (in.br | in.jal | in.jalr);
        drive(in);
        sb.push_back(e);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        chk({nm, ".validE"}, {31'd0, validE}, {31'd0, x.valid});
        chk({nm, ".PCsrcE"}, {31'd0, PCsrcE}, {31'd0, x.pcsrc});
        chk({nm, ".flushD"}, {31'd0, flushD}, {31'd0, x.flush});
        chk({nm, ".PCplusImmE"}, PCplusImmE, x.tgt);
        chk({nm, ".linkE"}, linkE, x.link);
`ifdef BRANCH_STATS_EN
        chk({nm, ".branch_cnt"}, branch_cnt, exp_br_cnt);
        chk({nm, ".taken_cnt"}, taken_cnt, exp_tk_cnt);
`endif
        if (x.ctl) exp_br_cnt++;
        if (x.pcsrc) exp_tk_cnt++;
    endtask

    vec_t tab[17];

    initial begin
        // {inputs} {valid, pcsrc, flush, target, link}
        tab[0]  = '{mki(1,1,0,0,3'b000,32'd5,32'd5,32'h20,32'h100),
                    mko(1,1,1,32'h120,32'h104)};
        tab[1]  = '{mki(1,1,0,0,3'b001,32'd5,32'd5,32'h40,32'h200),
                    mko(1,0,0,32'h0,32'h204)};
        tab[2]  = '{mki(1,1,0,0,3'b001,32'd5,32'd6,32'h40,32'h200),
                    mko(1,1,1,32'h240,32'h204)};
        tab[3]  = '{mki(1,1,0,0,3'b100,32'hFFFFFFFF,32'd1,32'h10,32'h300),
                    mko(1,1,1,32'h310,32'h304)};
        tab[4]  = '{mki(1,1,0,0,3'b110,32'hFFFFFFFF,32'd1,32'h10,32'h300),
                    mko(1,0,0,32'h0,32'h304)};
        tab[5]  = '{mki(1,1,0,0,3'b101,32'd1,32'hFFFFFFFF,32'hFFFFFFF0,32'h400),
                    mko(1,1,1,32'h3F0,32'h404)};
        tab[6]  = '{mki(1,1,0,0,3'b111,32'd1,32'hFFFFFFFF,32'hFFFFFFF0,32'h400),
                    mko(1,0,0,32'h0,32'h404)};
        tab[7]  = '{mki(1,1,0,0,3'b100,32'd3,32'd3,32'h8,32'h500),
                    mko(1,0,0,32'h0,32'h504)};
        tab[8]  = '{mki(1,1,0,0,3'b101,32'd3,32'd3,32'h8,32'h500),
                    mko(1,1,1,32'h508,32'h504)};
        tab[9]  = '{mki(1,1,0,0,3'b110,32'd1,32'd2,32'h100,32'h600),
                    mko(1,1,1,32'h700,32'h604)};
        tab[10] = '{mki(1,1,0,0,3'b111,32'd2,32'd2,32'h4,32'h600),
                    mko(1,1,1,32'h604,32'h604)};
        tab[11] = '{mki(1,1,0,0,3'b010,32'd9,32'd9,32'h4,32'h700),
                    mko(1,0,0,32'h0,32'h704)};
        tab[12] = '{mki(1,0,0,1,3'b000,32'h203,32'd0,32'h4,32'h1000),
                    mko(1,1,1,32'h206,32'h1004)};
        tab[13] = '{mki(1,0,1,0,3'b000,32'd0,32'd0,32'h8,32'hFFFFFFFC),
                    mko(1,1,1,32'h4,32'h0)};
        tab[14] = '{mki(1,1,1,1,3'b001,32'h101,32'h101,32'h10,32'h2000),
                    mko(1,1,1,32'h110,32'h2004)};
        tab[15] = '{mki(1,1,1,0,3'b001,32'h7,32'h7,32'h20,32'h3000),
                    mko(1,1,1,32'h3020,32'h3004)};
        tab[16] = '{mki(1,0,0,0,3'b011,32'd1,32'd1,32'h4,32'h40),
                    mko(1,0,0,32'h0,32'h44)};

        rst = 1'b0;
        drive(idle_in);
        repeat (2) @(posedge clk);
        #1;
        chk("reset.validE", {31'd0, validE}, 32'd0);
        chk("reset.PCsrcE", {31'd0, PCsrcE}, 32'd0);
        chk("reset.flushD", {31'd0, flushD}, 32'd0);
        chk("reset.PCplusImmE", PCplusImmE, 32'd0);
        chk("reset.linkE", linkE, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 17; i++) begin
            step(tab[i].i, tab[i].o, $sformatf("vec%0d", i));
            step(idle_in, mko(0,0,tab[i].o.pcsrc,32'h0,32'h0), $sformatf("vec%0d.idle1", i));
            step(idle_in, mko(0,0,0,32'h0,32'h0), $sformatf("vec%0d.idle2", i));
        end

        // Invalid decode slot carrying a jal is a bubble.
        step(mki(0,0,1,0,3'b000,32'd0,32'd0,32'h8,32'h80), mko(0,0,0,32'h0,32'h0), "novalid");

        // Taken branch then two valid jumps: both squashed, then normal flow.
        step(mki(1,1,0,0,3'b000,32'd1,32'd1,32'h10,32'h800), mko(1,1,1,32'h810,32'h804), "sq.br");
        step(mki(1,0,1,0,3'b000,32'd0,32'd0,32'h40,32'h804), mko(0,0,1,32'h0,32'h0), "sq.w1");
        step(mki(1,0,1,0,3'b000,32'd0,32'd0,32'h40,32'h808), mko(0,0,0,32'h0,32'h0), "sq.w2");
        step(mki(1,0,0,0,3'b000,32'd0,32'd0,32'h0,32'h810), mko(1,0,0,32'h0,32'h814), "sq.ok");
        step(idle_in, mko(0,0,0,32'h0,32'h0), "sq.idle");

        // Not-taken branch followed directly by a taken one.
        step(mki(1,1,0,0,3'b001,32'd7,32'd7,32'h100,32'h900), mko(1,0,0,32'h0,32'h904), "nt.1");
        step(mki(1,1,0,0,3'b000,32'd7,32'd7,32'h100,32'h904), mko(1,1,1,32'hA04,32'h908), "nt.2");
        step(idle_in, mko(0,0,1,32'h0,32'h0), "nt.idle1");
        step(idle_in, mko(0,0,0,32'h0,32'h0), "nt.idle2");

        // Reset asserted during SQUASH.
        step(mki(1,1,0,0,3'b000,32'd1,32'd1,32'h40,32'hA00), mko(1,1,1,32'hA40,32'hA04), "rs.br");
        drive(idle_in);
        @(posedge clk);
        #2;
        chk("rs.squash.flushD", {31'd0, flushD}, 32'd1);
        rst = 1'b0;
        #1;
        chk("rs.validE", {31'd0, validE}, 32'd0);
        chk("rs.PCsrcE", {31'd0, PCsrcE}, 32'd0);
        chk("rs.flushD", {31'd0, flushD}, 32'd0);
        chk("rs.PCplusImmE", PCplusImmE, 32'd0);
        chk("rs.linkE", linkE, 32'd0);
`ifdef BRANCH_STATS_EN
        chk("rs.branch_cnt", branch_cnt, 32'd0);
        chk("rs.taken_cnt", taken_cnt, 32'd0);
`endif
        exp_br_cnt = 0;
        exp_tk_cnt = 0;
        @(negedge clk);
        rst = 1'b1;
        step(mki(1,0,0,0,3'b000,32'd0,32'd0,32'h0,32'hB00), mko(1,0,0,32'h0,32'hB04), "rs.after");
        step(idle_in, mko(0,0,0,32'h0,32'h0), "rs.idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
